// File: rtl/mac_result_collector.sv
// mac_result_collector: realigns {valid,last} tags with the multiplier product P, accumulates each group, queues results (2 entries).
// Latency: MULT_LAT+1 cycles from the last operand accept to res_valid; sustains one product per cycle.
// Backpressure: op_ready only while queue occupancy + lasts in flight < 2; a pop frees credit on the following cycle.
// Build option: define MAC_SAT_EN to clamp each add to the signed ACC_WID range and report it on res_sat.

module mac_result_collector #(
  parameter int DATA_WID = 16,
  parameter int MULT_LAT = 3,
  parameter int ACC_WID  = 36,
  parameter int CNT_WID  = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  op_valid,
  input  logic                  op_last,
  output logic                  op_ready,
  input  logic [2*DATA_WID-1:0] p_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WID-1:0]    res_data,
  output logic [CNT_WID-1:0]    res_cnt,
  output logic                  res_sat
);

  typedef struct packed {
    logic [ACC_WID-1:0] data;
    logic [CNT_WID-1:0] cnt;
    logic               sat;
  } res_t;

  logic [MULT_LAT-1:0] tag_vld;
  logic [MULT_LAT-1:0] tag_last;
  logic [ACC_WID-1:0]  acc_q;
  logic [CNT_WID-1:0]  cnt_q;
  logic                sat_q;
  logic                grp_open;   // 0: the next qualified product starts a new group
  res_t                q_ent [2];  // q_ent[0] is the head
  logic [1:0]          q_cnt;
  logic [3:0]          inflight;

  logic                accept;
  logic                qual;
  logic                qual_last;
  logic                push;
  logic                pop;
  logic [ACC_WID-1:0]  p_ext;
  logic [ACC_WID-1:0]  add_res;
  logic                add_ovf;
  logic [ACC_WID-1:0]  grp_sum;
  logic [CNT_WID-1:0]  grp_cnt;
  logic                grp_sat;
  res_t                push_ent;

  assign accept    = op_valid && op_ready;
  assign qual      = tag_vld[MULT_LAT-1];
  assign qual_last = tag_last[MULT_LAT-1];
  assign push      = qual && qual_last;
  assign pop       = res_valid && res_ready;
  assign p_ext     = ACC_WID'($signed(p_in));

  // Every last still travelling through the multiplier already owns a queue slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MULT_LAT; i++) inflight = inflight + {3'b000, tag_last[i]};
  end

  assign op_ready = rst_n && !clr && (({2'b00, q_cnt} + inflight) < 4'd2);

`ifdef MAC_SAT_EN
  logic [ACC_WID:0] add_full;

  // One extra bit exposes overflow; clamp toward the sign of the true sum.
  always_comb begin
    add_full = {acc_q[ACC_WID-1], acc_q} + {p_ext[ACC_WID-1], p_ext};
    add_ovf  = add_full[ACC_WID] ^ add_full[ACC_WID-1];
    add_res  = add_full[ACC_WID-1:0];
    if (add_ovf) add_res = add_full[ACC_WID] ? {1'b1, {(ACC_WID-1){1'b0}}} : {1'b0, {(ACC_WID-1){1'b1}}};
  end
`else
  assign add_res = acc_q + p_ext;
  assign add_ovf = 1'b0;
`endif

  // First element of a group loads the product; later elements add onto the running sum.
  always_comb begin
    grp_sum  = grp_open ? add_res : p_ext;
    grp_cnt  = grp_open ? cnt_q + CNT_WID'(1) : CNT_WID'(1);
    grp_sat  = grp_open && (sat_q || add_ovf);
    push_ent = '{data: grp_sum, cnt: grp_cnt, sat: grp_sat};
  end

  // Tag pipeline mirrors the multiplier so each product emerges with its valid/last.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else if (clr) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else begin
      tag_vld[0]  <= accept;
      tag_last[0] <= accept && op_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Running group state advances only on qualified products; a last returns to the first-element state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      grp_open <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      grp_open <= 1'b0;
    end else if (qual) begin
      if (qual_last) begin
        grp_open <= 1'b0;
      end else begin
        acc_q    <= grp_sum;
        cnt_q    <= grp_cnt;
        sat_q    <= grp_sat;
        grp_open <= 1'b1;
      end
    end
  end

  // Two-entry result queue; push and pop may coincide at any occupancy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_ent[0] <= '0;
      q_ent[1] <= '0;
      q_cnt    <= 2'd0;
    end else if (clr) begin
      q_ent[0] <= '0;
      q_ent[1] <= '0;
      q_cnt    <= 2'd0;
    end else begin
      case (q_cnt)
        2'd0: begin
          if (push) begin
            q_ent[0] <= push_ent;
            q_cnt    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            q_ent[0] <= push_ent;
          end else if (push) begin
            q_ent[1] <= push_ent;
            q_cnt    <= 2'd2;
          end else if (pop) begin
            q_cnt    <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            q_ent[0] <= q_ent[1];
            if (push) q_ent[1] <= push_ent;
            else      q_cnt    <= 2'd1;
          end
        end
      endcase
    end
  end

  assign res_valid = (q_cnt != 2'd0);
  assign res_data  = q_ent[0].data;
  assign res_cnt   = q_ent[0].cnt;
  assign res_sat   = q_ent[0].sat;

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: models the signed multiplier pipeline and a group-level reference.
// Directed scenarios plus a randomized run with occasional flushes.
module tb_mac_result_collector;

  localparam int DW = 16;
  localparam int ML = 3;
  localparam int AW = 36;
  localparam int CW = 8;
  localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW-1));

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic op_valid = 1'b0;
  logic op_last = 1'b0;
  logic op_ready;
  logic [2*DW-1:0] p_in;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [AW-1:0] res_data;
  logic [CW-1:0] res_cnt;
  logic res_sat;

  logic signed [DW-1:0]   a_op = '0;
  logic signed [DW-1:0]   b_op = '0;
  logic signed [2*DW-1:0] pipe [ML];

  mac_result_collector #(.DATA_WID(DW), .MULT_LAT(ML), .ACC_WID(AW), .CNT_WID(CW)) dut (
    .clock(clock), .rst_n(rst_n), .clr(clr), .op_valid(op_valid), .op_last(op_last),
    .op_ready(op_ready), .p_in(p_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cnt(res_cnt), .res_sat(res_sat));

  always #5 clock = ~clock;

  // Stand-in for the pipelined signed multiplier: product of the operands at edge T appears for edge T+ML.
  always @(posedge clock) begin
    pipe[0] <= 32'(a_op) * 32'(b_op);
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign p_in = pipe[ML-1];

  // ---------------- reference model (group level) ----------------
  typedef struct {
    longint data;
    int     cnt;
    bit     sat;
    int     due;
  } exp_t;

  exp_t   expq[$];
  int     cyc = 0;
  int     outstanding = 0;
  longint grp_sum = 0;
  int     grp_cnt = 0;
  bit     grp_sat = 0;
  bit     grp_open = 0;
  int     n_chk = 0;
  int     n_pass = 0;

  function automatic bit exp_ready();
    return rst_n && !clr && (outstanding < 2);
  endfunction

  function automatic bit exp_valid();
    return (expq.size() > 0) && (expq[0].due <= cyc);
  endfunction

  task automatic model_flush();
    expq.delete();
    outstanding = 0;
    grp_open = 0;
    grp_sum = 0;
    grp_cnt = 0;
    grp_sat = 0;
  endtask

  task automatic model_accept(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b, input bit last);
    longint p;
    longint s;
    exp_t   e;
    p = longint'(a) * longint'(b);
    if (!grp_open) begin
      s = p;
      grp_cnt = 1;
      grp_sat = 0;
    end else begin
      s = grp_sum + p;
      grp_cnt++;
`ifdef MAC_SAT_EN
      if (s > AMAX) begin s = AMAX; grp_sat = 1; end
      else if (s < AMIN) begin s = AMIN; grp_sat = 1; end
`else
      s = (s <<< (64-AW)) >>> (64-AW);
`endif
    end
    grp_sum = s;
    if (last) begin
      e.data = s; e.cnt = grp_cnt; e.sat = grp_sat; e.due = cyc + ML;
      expq.push_back(e);
      outstanding++;
      grp_open = 0;
    end else begin
      grp_open = 1;
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input bit v, input bit l, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rr);
    op_valid = v; op_last = l; a_op = a; b_op = b; res_ready = rr;
    #1;
  endtask

  task automatic tick();
    bit acc_op;
    bit pop;
    acc_op = op_valid && exp_ready();
    pop    = exp_valid() && res_ready;
    @(posedge clock);
    cyc++;
    if (clr) begin
      model_flush();
    end else begin
      if (pop) begin
        void'(expq.pop_front());
        outstanding--;
      end
      if (acc_op) model_accept(a_op, b_op, op_last);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0, '0, rr);
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if (op_ready !== 1'b0) $display("FAIL reset_op_ready: got %0b want 0", op_ready); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", res_valid); else n_pass++;
    n_chk++; if (res_data !== '0) $display("FAIL reset_res_data: got %h want 0", res_data); else n_pass++;
    n_chk++; if (res_cnt !== '0) $display("FAIL reset_res_cnt: got %0d want 0", res_cnt); else n_pass++;
    n_chk++; if (res_sat !== 1'b0) $display("FAIL reset_res_sat: got %0b want 0", res_sat); else n_pass++;
    rst_n = 1'b1;
    model_flush();
    #1;
    n_chk++; if (op_ready !== 1'b1) $display("FAIL reset_release_op_ready: got %0b want 1", op_ready); else n_pass++;
  endtask

  task automatic test_group_signed();
    // op_last without op_valid must not create a result
    for (int i = 0; i < ML + 1; i++) begin
      drive(0, 1, 16'h0001, 16'h0001, 0);
      tick();
    end
    n_chk++; if (res_valid !== 1'b0) $display("FAIL stray_last_valid: got %0b want 0", res_valid); else n_pass++;
    drive(1, 0, 16'hFFFF, 16'hFFF9, 0); tick();
    drive(1, 1, 16'hFFFD, 16'hFFFA, 0); tick();
    for (int i = 0; i < ML; i++) begin
      n_chk++; if (res_valid !== 1'b0) $display("FAIL grp2_early_valid: cycle %0d got %0b want 0", i, res_valid); else n_pass++;
      drive(0, 0, '0, '0, 0); tick();
    end
    n_chk++; if (res_valid !== 1'b1) $display("FAIL grp2_valid: got %0b want 1", res_valid); else n_pass++;
    n_chk++; if (res_data !== 36'd25) $display("FAIL grp2_data: got %0d want 25", $signed(res_data)); else n_pass++;
    n_chk++; if (res_cnt !== 8'd2) $display("FAIL grp2_cnt: got %0d want 2", res_cnt); else n_pass++;
    n_chk++; if (res_sat !== 1'b0) $display("FAIL grp2_sat: got %0b want 0", res_sat); else n_pass++;
    idle(1, 1);
    n_chk++; if (res_valid !== 1'b0) $display("FAIL grp2_pop: got %0b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 16'h0002, 16'h0003, 0); tick();
    n_chk++; if (op_ready !== 1'b1) $display("FAIL b2b_ready_one: got %0b want 1", op_ready); else n_pass++;
    drive(1, 1, 16'h0004, 16'h0005, 0); tick();
    n_chk++; if (op_ready !== 1'b0) $display("FAIL b2b_ready_two: got %0b want 0", op_ready); else n_pass++;
    idle(ML + 2, 0);
    n_chk++; if (res_valid !== 1'b1) $display("FAIL b2b_valid: got %0b want 1", res_valid); else n_pass++;
    n_chk++; if (res_data !== 36'd6) $display("FAIL b2b_head0: got %0d want 6", $signed(res_data)); else n_pass++;
    drive(0, 0, '0, '0, 1);
    n_chk++; if (op_ready !== 1'b0) $display("FAIL b2b_ready_pop_cycle: got %0b want 0", op_ready); else n_pass++;
    tick();
    n_chk++; if (op_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %0b want 1", op_ready); else n_pass++;
    n_chk++; if (res_data !== 36'd20 || res_valid !== 1'b1) $display("FAIL b2b_head1: got %0d/%0b want 20/1", $signed(res_data), res_valid); else n_pass++;
    idle(1, 1);
    n_chk++; if (res_valid !== 1'b0) $display("FAIL b2b_empty: got %0b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_group8();
    for (int i = 0; i < 8; i++) begin
      drive(1, i == 7, 16'h7FFF, 16'h7FFF, 0); tick();
    end
    idle(ML, 0);
    n_chk++; if (res_data !== 36'h1FFF80008) $display("FAIL grp8_data: got %h want 1fff80008", res_data); else n_pass++;
    n_chk++; if (res_cnt !== 8'd8) $display("FAIL grp8_cnt: got %0d want 8", res_cnt); else n_pass++;
    idle(1, 1);
  endtask

  task automatic test_saturation();
    logic [AW-1:0] want_d;
    logic          want_s;
    drive(1, 0, 16'h8000, 16'h8000, 0); tick();
    drive(1, 1, 16'h8000, 16'h8000, 0); tick();
    idle(ML, 0);
    n_chk++; if (res_data !== 36'h080000000 || res_sat !== 1'b0) $display("FAIL sat2_result: got %h/%0b want 080000000/0", res_data, res_sat); else n_pass++;
    idle(1, 1);
    for (int i = 0; i < 32; i++) begin
      drive(1, i == 31, 16'h8000, 16'h8000, 0); tick();
    end
    idle(ML, 0);
`ifdef MAC_SAT_EN
    want_d = 36'h7FFFFFFFF; want_s = 1'b1;
`else
    want_d = 36'h800000000; want_s = 1'b0;
`endif
    n_chk++; if (res_data !== want_d) $display("FAIL sat32_data: got %h want %h", res_data, want_d); else n_pass++;
    n_chk++; if (res_sat !== want_s) $display("FAIL sat32_flag: got %0b want %0b", res_sat, want_s); else n_pass++;
    n_chk++; if (res_cnt !== 8'd32) $display("FAIL sat32_cnt: got %0d want 32", res_cnt); else n_pass++;
    idle(1, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'(i + 3), 16'h0011, 0); tick();
    end
    clr = 1'b1;
    drive(0, 0, '0, '0, 0);
    n_chk++; if (op_ready !== 1'b0) $display("FAIL flush_op_ready: got %0b want 0", op_ready); else n_pass++;
    tick();
    clr = 1'b0;
    for (int i = 0; i < ML + 2; i++) begin
      drive(0, 0, '0, '0, 0); tick();
      n_chk++; if (res_valid !== 1'b0) $display("FAIL flush_no_result: cycle %0d got %0b want 0", i, res_valid); else n_pass++;
    end
    drive(1, 1, 16'h0001, 16'h0001, 0); tick();
    idle(ML, 0);
    n_chk++; if (res_data !== 36'd1 || res_cnt !== 8'd1) $display("FAIL flush_next: got %0d/%0d want 1/1", $signed(res_data), res_cnt); else n_pass++;
    idle(1, 1);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 16'h0003, 16'h0003, 0); tick();
    idle(ML, 0);
    n_chk++; if (res_valid !== 1'b1 || res_data !== 36'd9) $display("FAIL rstmid_queued: got %0b/%0d want 1/9", res_valid, $signed(res_data)); else n_pass++;
    drive(1, 1, 16'h0005, 16'h0005, 0); tick();
    drive(0, 0, '0, '0, 0);
    rst_n = 1'b0;
    #1;
    n_chk++; if (op_ready !== 1'b0 || res_valid !== 1'b0) $display("FAIL rstmid_ctrl: got ready %0b valid %0b want 0/0", op_ready, res_valid); else n_pass++;
    n_chk++; if (res_data !== '0 || res_cnt !== '0 || res_sat !== 1'b0) $display("FAIL rstmid_data: got %h/%0d/%0b want 0/0/0", res_data, res_cnt, res_sat); else n_pass++;
    model_flush();
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < ML + 3; i++) begin
      drive(0, 0, '0, '0, 0); tick();
      n_chk++; if (res_valid !== 1'b0) $display("FAIL rstmid_stale: cycle %0d got %0b want 0", i, res_valid); else n_pass++;
    end
    n_chk++; if (op_ready !== 1'b1) $display("FAIL rstmid_ready: got %0b want 1", op_ready); else n_pass++;
    drive(1, 1, 16'h0002, 16'h0002, 0); tick();
    idle(ML, 0);
    n_chk++; if (res_data !== 36'd4 || res_cnt !== 8'd1) $display("FAIL rstmid_next: got %0d/%0d want 4/1", $signed(res_data), res_cnt); else n_pass++;
    idle(1, 1);
  endtask

  task automatic test_random();
    bit v, l, rr;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 60) == 0);
      drive(v, l, 16'($urandom), 16'($urandom), rr);
      n_chk++; if (op_ready !== exp_ready()) $display("FAIL rnd_op_ready: cycle %0d got %0b want %0b", n, op_ready, exp_ready()); else n_pass++;
      n_chk++; if (res_valid !== exp_valid()) $display("FAIL rnd_res_valid: cycle %0d got %0b want %0b", n, res_valid, exp_valid()); else n_pass++;
      if (exp_valid()) begin
        n_chk++;
        if (longint'($signed(res_data)) !== expq[0].data || res_cnt !== CW'(expq[0].cnt) || res_sat !== expq[0].sat)
          $display("FAIL rnd_head: cycle %0d got %0d/%0d/%0b want %0d/%0d/%0b", n, $signed(res_data), res_cnt, res_sat,
                   expq[0].data, CW'(expq[0].cnt), expq[0].sat);
        else n_pass++;
      end
      tick();
    end
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_group_signed();
    test_back_to_back();
    test_group8();
    test_saturation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Consumer end of the DSP48 multiplier path in mini Davinci. Tracks operands issued to the pipelined signed multiplier (`mult_gen_0`, latency `MULT_LAT`) and realigns a valid/last tag with the product `P`. Accumulates each product group into a dot-product result and delivers results through a 2-entry valid/ready output queue. Sits between the operand sequencer and the result writeback.

## Interface
- `DATA_WID`, 16, operand width; the product is `2*DATA_WID` bits, signed two's complement.
- `MULT_LAT`, 3, multiplier pipeline latency in cycles; allowed range is 1 to 8.
- `ACC_WID`, 36, accumulator and result width; must be ≥ `2*DATA_WID`.
- `CNT_WID`, 8, element-count width.
- `clock`, in, 1, rising-edge clock.
- `rst_n`, in, 1, reset, asynchronous, active-low.
- `clr`, in, 1, synchronous flush of all state.
- `op_valid`, in, 1, an operand pair is presented to the multiplier this cycle.
- `op_last`, in, 1, this operand pair closes the current group.
- `op_ready`, out, 1, the operand pair is accepted when `op_valid && op_ready`.
- `p_in`, in, `2*DATA_WID`, multiplier output `P`.
- `res_valid`, out, 1, the queue head holds a result.
- `res_ready`, in, 1, downstream accepts the head.
- `res_data`, out, `ACC_WID`, signed dot-product result.
- `res_cnt`, out, `CNT_WID`, number of elements in the result's group; wraps at the counter width.
- `res_sat`, out, 1, saturation occurred in the group.

## Operation
- **Tag pipeline**: a `MULT_LAT`-deep shift register carries {valid, last}.
  - Stage 0 is loaded with `op_valid && op_ready` and `op_last`.
  - The tag emerging at the tail qualifies the current `p_in`.
- **Accumulate**: when a qualified tag arrives and it is the first element of a group, the accumulator loads `sext(p_in)`; otherwise it adds `sext(p_in)`. The element counter follows the same load/add pattern.
- **Last element**: `acc + p` (or `p` alone for a 1-element group) is pushed into the queue together with the count and the sat flag. The accumulator returns to the first-element state.
- **Queue**: 2 entries.
  - Push and pop in the same cycle are allowed, including when the queue is full.
  - `res_data`, `res_cnt` and `res_sat` reflect the head.
- **Credits**:
  - `inflight` counts lasts in the tag pipeline.
  - `op_ready = !clr && (queue_count + inflight < 2)`.
  - A pop in the current cycle does not raise `op_ready` until the next cycle.
- **Flush (`clr`)**: empties the tag pipeline, accumulator, counter and queue at the clock edge. Products still in the multiplier are ignored.
- **Reset (`rst_n` low)**, including mid-group: every register is cleared immediately.
  - `op_ready = 0` while `rst_n` is low.
  - `res_valid = 0`, `res_data = 0`, `res_cnt = 0`, `res_sat = 0`.
  - After release, `op_ready` is 1.

## Timing
- An op accepted at edge T is sampled from `p_in` at edge T+`MULT_LAT`.
- For a last op accepted at edge T, `res_valid` rises after edge T+`MULT_LAT` (registered queue), so latency is `MULT_LAT`+1 cycles.
- Back-to-back accepted ops sustain 1 product per cycle.
- A 1-element group is legal.
- Groups may stall mid-way, since accumulation only advances on qualified tags.
- `op_last` without `op_valid` is ignored.

## Configuration
- `MAC_SAT_EN` defined:
  - Each add is clamped to the signed `ACC_WID` min/max.
  - Any clamp sets the group's `res_sat` flag.
- `MAC_SAT_EN` undefined:
  - Arithmetic wraps modulo 2^`ACC_WID`.
  - `res_sat` is tied to 0.

## Test plan
- **Group of 2, signed**: ops (0xFFFF×0xFFF9) then (0xFFFD×0xFFFA, last) → single result `res_data`=25, `res_cnt`=2, `res_valid` high `MULT_LAT`+1 cycles after the last op.
- **Back-to-back 1-element groups** with `res_ready`=0: 0x0002×0x0003 last, then 0x0004×0x0005 last → `op_ready` drops after the second accept; queue holds 6 then 20. Raising `res_ready` pops in order, and `op_ready` returns one cycle after the first pop.
- **8-element group**, each op 0x7FFF×0x7FFF → result 8×0x3FFF0001 = 0x1FFF80008, `res_cnt`=8.
- **Saturation**, with `ACC_WID`=32 and `MAC_SAT_EN` defined: two ops of 0x8000×0x8000 (0x40000000 each) → `res_data`=0x7FFFFFFF, `res_sat`=1. With the macro undefined → `res_data`=0x80000000, `res_sat`=0.
- **Flush mid-group**: after 3 ops of a group, pulse `clr` → no result is emitted. The next 1-element group 0x0001×0x0001 yields 1 with `res_cnt`=1.
- **Reset mid-operation**: assert `rst_n` low with a last op in flight and one result queued → all outputs go to 0 immediately, and no stale result appears after release.
